// File: rtl/sram_stream_reader.sv
// Burst reader: issues sequential SRAM reads from base_adr and streams the words
// out through a 2-entry FIFO with valid/ready handshake and a last-beat marker.
module sram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_adr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  ren,
    output logic [ADDR_WIDTH-1:0] radr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] adr_q;
    logic [LEN_W-1:0]      rem_q;
    logic                  pend_q;
    logic                  pend_last_q;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            cnt;

    logic                  push;
    logic                  pop;
    logic [2:0]            occ;
    logic                  issue_ok;

    assign push      = pend_q;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign radr      = adr_q;
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];

    // Occupancy once the word on rdata lands, net of this cycle's pop; keeps FIFO from overflowing.
    assign occ      = 3'(cnt) + 3'(pend_q) - 3'(pop);
    assign issue_ok = (occ < 3'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ren && (rem_q == LEN_W'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        ren  = 1'b0;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_ISSUE: begin
                busy = 1'b1;
                ren  = issue_ok;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Address / remaining-count tracking and in-flight read marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q       <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q <= ren;
            if (state == S_IDLE && start && len != '0) begin
                adr_q <= base_adr;
                rem_q <= len;
            end else if (ren) begin
                adr_q       <= adr_q + ADDR_WIDTH'(1);
                rem_q       <= rem_q - LEN_W'(1);
                pend_last_q <= (rem_q == LEN_W'(1));
            end
        end
    end

    // Two-entry output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rdata;
                fifo_last[wr_ptr] <= pend_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: SRAM model, expected address/beat queues,
// and a negedge monitor that checks every read, beat, stall and done pulse.
module tb_sram_stream_reader;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_adr;
    logic [AW:0]   len_in;
    logic          busy, done, ren;
    logic [AW-1:0] radr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;

    sram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len_in),
        .busy(busy), .done(done), .ren(ren), .radr(radr), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] sram [1024];
    beat_t         exp_beats [$];
    logic [AW-1:0] exp_adrs [$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int issued = 0;
    int popped = 0;
    int ready_mode = 0;
    int ready_idx = 0;
    logic          stall_prev = 1'b0;
    logic          done_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    // SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (ren) rdata <= sram[radr];
    end

    // Consumer back-pressure: 0 = always ready, 1 = pattern 1,0,0, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (ready_idx % 3 == 0);
                ready_idx++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: values seen here are what the next rising edge acts on
    always @(negedge clk) begin
        if (rst_n) begin
            if (ren) begin
                if (exp_adrs.size() == 0) flag("unexpected_ren");
                else chk("radr", DW'(radr), DW'(exp_adrs.pop_front()));
                issued++;
            end
            if (out_valid) begin
                chk("busy_with_beat", DW'(busy), DW'(1));
                if (stall_prev) chk("stall_hold", out_data, stall_data);
                if (out_ready) begin
                    if (exp_beats.size() == 0) begin
                        flag("unexpected_beat");
                    end else begin
                        beat_t b;
                        b = exp_beats.pop_front();
                        chk("out_data", out_data, b.data);
                        chk("out_last", DW'(out_last), DW'(b.last));
                    end
                    popped++;
                end
            end else if (stall_prev) begin
                chk("stall_valid", DW'(out_valid), DW'(1));
            end
            if (ren) chk("reads_ahead", DW'((issued - popped) <= 2), DW'(1));
            if (done) begin
                done_cnt++;
                if (exp_beats.size() != 0) flag("done_before_last");
                if (done_prev) flag("done_two_cycles");
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            done_prev  = done;
        end else begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end
    end

    task automatic push_expect(input logic [AW-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            exp_adrs.push_back(AW'(base + i));
            b.data = sram[AW'(base + i)];
            b.last = (i == n - 1);
            exp_beats.push_back(b);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", DW'(busy), '0);
        chk("rst_done", DW'(done), '0);
        chk("rst_ren", DW'(ren), '0);
        chk("rst_radr", DW'(radr), '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_last", DW'(out_last), '0);
        chk("rst_out_data", out_data, '0);
    endtask

    task automatic wait_done(input int d0, input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) got = 1'b1;
        end
        chk("done_seen", DW'(got), DW'(1));
        repeat (2) @(negedge clk);
        #1;
        chk("done_once", DW'(done_cnt - d0), DW'(1));
        chk("beats_left", DW'(exp_beats.size()), '0);
        chk("reads_left", DW'(exp_adrs.size()), '0);
    endtask

    task automatic run_burst(input logic [AW-1:0] base, input int n, input int mode, input bit poke);
        int d0;
        ready_mode = mode;
        ready_idx  = 0;
        @(posedge clk);
        #2;
        start    = 1'b1;
        base_adr = base;
        len_in   = (AW + 1)'(n);
        push_expect(base, n);
        d0 = done_cnt;
        @(posedge clk);
        #2;
        start = 1'b0;
        if (poke) begin
            // Second start while busy must not disturb the burst
            repeat (3) @(posedge clk);
            #2;
            start    = 1'b1;
            base_adr = AW'(500);
            len_in   = (AW + 1)'(3);
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        wait_done(d0, n * 4 + 40);
    endtask

    initial begin
        int d0;
        int p0;
        bit got;
        rst_n    = 1'b0;
        start    = 1'b0;
        base_adr = '0;
        len_in   = '0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 1024; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single word: exact latency of ren, first beat and done
        sram[97]   = DW'(137);
        ready_mode = 0;
        @(posedge clk);
        #2;
        start    = 1'b1;
        base_adr = AW'(97);
        len_in   = (AW + 1)'(1);
        push_expect(AW'(97), 1);
        d0 = done_cnt;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        chk("t_ren", DW'(ren), DW'(1));
        chk("t_radr", DW'(radr), DW'(97));
        chk("t_busy", DW'(busy), DW'(1));
        @(negedge clk);
        chk("t_valid_early", DW'(out_valid), '0);
        @(negedge clk);
        chk("t_valid", DW'(out_valid), DW'(1));
        chk("t_data", out_data, DW'(137));
        chk("t_last", DW'(out_last), DW'(1));
        @(negedge clk);
        chk("t_done", DW'(done), DW'(1));
        wait_done(d0, 10);

        // Eight words, full rate, then with stalls and an ignored start
        for (int i = 0; i < 8; i++) sram[i] = DW'(i);
        run_burst(AW'(0), 8, 0, 1'b0);
        run_burst(AW'(0), 8, 1, 1'b1);

        // Address wrap and empty burst
        run_burst(AW'(1022), 4, 2, 1'b0);
        run_burst(AW'(5), 0, 0, 1'b0);

        // Reset in the middle of a burst
        ready_mode = 0;
        @(posedge clk);
        #2;
        start    = 1'b1;
        base_adr = '0;
        len_in   = (AW + 1)'(8);
        push_expect(AW'(0), 8);
        p0 = popped;
        @(posedge clk);
        #2;
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            #1;
            if (popped - p0 >= 3) got = 1'b1;
        end
        chk("three_beats_seen", DW'(got), DW'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_beats.delete();
        exp_adrs.delete();
        issued = 0;
        popped = 0;
        d0 = done_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("no_done_after_abort", DW'(done_cnt), DW'(d0));
        run_burst(AW'(0), 2, 0, 1'b0);

        // Whole address space, from a random start address
        for (int i = 0; i < 1024; i++) sram[i] = {$urandom, $urandom, $urandom, $urandom};
        run_burst(AW'($urandom_range(0, 1023)), 1024, 0, 1'b0);

        // Random bursts under random back-pressure
        for (int k = 0; k < 12; k++) begin
            run_burst(AW'($urandom_range(0, 1023)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 2)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set SRAM word and output stream width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set SRAM address width; SRAM depth is 2**ADDR_WIDTH.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port start, input, 1, SHALL request a burst read when high in IDLE.
REQ-006 Port base_adr, input, ADDR_WIDTH, SHALL give the first SRAM address, sampled with start.
REQ-007 Port len, input, ADDR_WIDTH+1, SHALL give the word count (0..2**ADDR_WIDTH), sampled with start.
REQ-008 Port busy, output, 1, SHALL be high whenever state is not IDLE.
REQ-009 Port done, output, 1, SHALL pulse high for one cycle at burst completion.
REQ-010 Port ren, output, 1, SHALL be the SRAM read enable.
REQ-011 Port radr, output, ADDR_WIDTH, SHALL be the SRAM read address.
REQ-012 Port rdata, input, DATA_WIDTH, SHALL carry SRAM read data, valid in the cycle after the cycle in which ren was high.
REQ-013 Port out_valid, output, 1, SHALL indicate out_data/out_last hold a valid beat.
REQ-014 Port out_ready, input, 1, SHALL indicate the consumer accepts a beat; a beat transfers on a clk edge with out_valid and out_ready both high.
REQ-015 Port out_data, output, DATA_WIDTH, SHALL carry the beat payload.
REQ-016 Port out_last, output, 1, SHALL mark the final beat of a burst.

Function
REQ-017 States SHALL be IDLE, ISSUE, DRAIN, with DONE as a one-cycle state that returns to IDLE.
REQ-018 IDLE + start with len>0 SHALL latch base_adr and len and go to ISSUE; with len=0 SHALL go to DONE and emit no beats.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 In ISSUE, the block SHALL assert ren with radr = (base_adr + i) mod 2**ADDR_WIDTH for i = 0..len-1 in order, at most one read per cycle.
REQ-021 A read SHALL issue only when (buffered beats + reads in flight) < 2; reads in flight is at most 1.
REQ-022 Read data SHALL be captured into a 2-entry FIFO in the cycle after ren; it SHALL never be dropped or overwritten.
REQ-023 out_valid SHALL be high iff the FIFO is non-empty; out_data SHALL be the FIFO head and hold stable while out_valid && !out_ready.
REQ-024 With out_ready held high, throughput SHALL be one beat per cycle after a first-beat latency of 2 cycles from start.
REQ-025 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-026 out_last SHALL be high only with the beat for i = len-1.
REQ-027 After the last read issues, state SHALL go to DRAIN; DRAIN SHALL go to DONE on the cycle the out_last beat transfers.
REQ-028 Address arithmetic SHALL wrap modulo 2**ADDR_WIDTH; len = 2**ADDR_WIDTH SHALL read every address exactly once.
REQ-029 ren SHALL be low in IDLE, DRAIN and DONE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, busy=0, done=0, ren=0, radr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, counters zero.
REQ-031 Reset mid-burst SHALL abort the burst; data returning from an in-flight read SHALL be discarded, no done pulse.

Verification
REQ-032 SRAM[97]=137, start base_adr=97 len=1, out_ready=1 -> ren with radr=97 next cycle; out_valid, out_data=137, out_last=1 two cycles after start; done pulses one cycle after transfer.
REQ-033 SRAM[i]=i for i=0..7, start base 0 len 8, out_ready=1 -> 8 consecutive beats 0..7, out_last only on 7, busy high throughout.
REQ-034 Same burst, out_ready toggles 1,0,0,1,... -> beats still 0..7 in order, no loss/duplication, out_data stable while stalled, at most 2 reads ahead of consumer.
REQ-035 start base 1022 len 4 (ADDR_WIDTH=10) -> radr sequence 1022,1023,0,1.
REQ-036 start len=0 -> no ren, no out_valid, done pulses once; start asserted while busy -> ignored.
REQ-037 rst_n low for one cycle after 3 of 8 beats -> all outputs at reset values immediately; subsequent start base 0 len 2 -> clean beats 0,1.
